// File: rtl/nibble_adder_seq_pkg.sv
// -----------------------------------------------------------------------------
// nibble_adder_seq_pkg
// Shared constants for the nibble-serial adder:
//   NIBBLE_W             - width of the shared adder slice (4 bits)
//   ST_IDLE/ST_RUN/ST_DONE - sequencer state encodings
//   idx_width()          - nibble index counter width, never less than 1
// -----------------------------------------------------------------------------
package nibble_adder_seq_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A single-nibble operand still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_adder_seq_ripple_adder.sv
// -----------------------------------------------------------------------------
// ripple_adder
// Purely combinational NIBBLE_W-bit ripple carry adder, used as the shared
// datapath slice of nibble_adder_seq.
// Ports:
//   a, b  in  NIBBLE_W  addends
//   ci    in  1         carry in
//   s     out NIBBLE_W  sum
//   co    out 1         carry out of the top bit
// -----------------------------------------------------------------------------
module ripple_adder
    import nibble_adder_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    logic [NIBBLE_W:0] c;

    assign c[0] = ci;

    generate
        for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
            assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign co = c[NIBBLE_W];

endmodule

// File: rtl/nibble_adder_seq.sv
// -----------------------------------------------------------------------------
// nibble_adder_seq
// Adds two W = 4*NIBBLES bit operands through one shared 4-bit ripple adder,
// one nibble per clock, least-significant nibble first, carry held in a
// register between nibbles. Start/busy/done handshake.
//
// Optional build macro: NIBBLE_ADDER_SUB_EN
//   When defined, adds input 'sub'; a start with sub=1 computes a - b mod 2^W
//   (b nibbles inverted into the slice, carry seeded with 1) and carry_out=1
//   then means "no borrow" (a >= b).
//
// Ports:
//   clock      in  1  rising-edge clock
//   reset_n    in  1  asynchronous active-low reset
//   start      in  1  request, accepted only in IDLE
//   op_a, op_b in  W  operands, captured on accepted start
//   sub        in  1  (macro only) subtract select, captured on accepted start
//   busy       out 1  high in RUN and DONE
//   done       out 1  one-cycle pulse, sum/carry_out valid
//   sum        out W  result of last completed operation (held)
//   carry_out  out 1  final carry of last completed operation (held)
// -----------------------------------------------------------------------------
module nibble_adder_seq
    import nibble_adder_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [NIBBLE_W*NIBBLES-1:0]  op_a,
    input  logic [NIBBLE_W*NIBBLES-1:0]  op_b,
`ifdef NIBBLE_ADDER_SUB_EN
    input  logic                         sub,
`endif
    output logic                         busy,
    output logic                         done,
    output logic [NIBBLE_W*NIBBLES-1:0]  sum,
    output logic                         carry_out
);

    localparam int IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    typedef logic [NIBBLES-1:0][NIBBLE_W-1:0] nib_vec_t;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    nib_vec_t         a_q, a_d;
    nib_vec_t         b_q, b_d;
    nib_vec_t         acc_q, acc_d;
    nib_vec_t         sum_q, sum_d;
    logic             carry_out_q, carry_out_d;

    logic [NIBBLE_W-1:0] slice_a;
    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_co;

    // b_mask inverts the b nibble for subtraction; carry_init seeds the
    // carry register on an accepted start (1 turns ~b into -b).
    logic [NIBBLE_W-1:0] b_mask;
    logic                carry_init;

`ifdef NIBBLE_ADDER_SUB_EN
    logic sub_q, sub_d;

    assign b_mask     = {NIBBLE_W{sub_q}};
    assign carry_init = sub;
`else
    assign b_mask     = '0;
    assign carry_init = 1'b0;
`endif

    assign slice_a = a_q[idx_q];
    assign slice_b = b_q[idx_q] ^ b_mask;

    ripple_adder u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
`ifdef NIBBLE_ADDER_SUB_EN
        sub_d       = sub_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    acc_d   = '0;
                    carry_d = carry_init;
                    idx_d   = '0;
`ifdef NIBBLE_ADDER_SUB_EN
                    sub_d   = sub;
`endif
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d[idx_q] = slice_s;
                carry_d      = slice_co;
                if (idx_q == IDX_LAST) begin
                    // Result registers load on the same edge the last nibble
                    // is written, so they are visible together with done.
                    sum_d       = acc_d;
                    carry_out_d = slice_co;
                    state_d     = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
`ifdef NIBBLE_ADDER_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
`ifdef NIBBLE_ADDER_SUB_EN
            sub_q       <= sub_d;
`endif
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign carry_out = carry_out_q;

endmodule
